// File: rtl/pulse_on_change.sv
// Registered, retriggerable pulse of PULSE_CYCLES clocks whenever the sampled data_in differs from the previous sample.
// Latency: pulse rises at the edge that samples the change; no flow control, the block accepts data every cycle.
module pulse_on_change #(
    parameter int WIDTH        = 8,
    parameter int PULSE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    output logic             pulse
);

    localparam int CNT_W = (PULSE_CYCLES < 1) ? 1 : $clog2(PULSE_CYCLES + 1);

    logic [WIDTH-1:0] prev_data_q;
    logic [WIDTH-1:0] prev_data_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pulse_q;
    logic             pulse_d;
    logic             change;

    always_comb begin
        prev_data_d = data_in;
        change      = (data_in != prev_data_q);
        cnt_d       = cnt_q;
        if (change) begin
            cnt_d = CNT_W'(PULSE_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        // pulse reflects the counter value after this edge, so it is high on the sampling edge itself
        pulse_d = (cnt_d != '0);
    end

    // rst_n is active-high despite its name
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            prev_data_q <= '0;
            cnt_q       <= '0;
            pulse_q     <= 1'b0;
        end else begin
            prev_data_q <= prev_data_d;
            cnt_q       <= cnt_d;
            pulse_q     <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: tb/tb_pulse_on_change.sv
// Directed bench: one instance with PULSE_CYCLES=1 and one with PULSE_CYCLES=4.
module tb_pulse_on_change;

    logic       clk = 1'b0;
    logic       rst_a;
    logic       rst_b;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic       pulse_a;
    logic       pulse_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pulse_on_change #(.WIDTH(8), .PULSE_CYCLES(1)) dut_a (
        .clk     (clk),
        .rst_n   (rst_a),
        .data_in (data_a),
        .pulse   (pulse_a)
    );

    pulse_on_change #(.WIDTH(8), .PULSE_CYCLES(4)) dut_b (
        .clk     (clk),
        .rst_n   (rst_b),
        .data_in (data_b),
        .pulse   (pulse_b)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive a value, let one rising edge sample it, then check the pulse just after the edge.
    task automatic step_a(input logic [7:0] v, input logic exp, input string tag);
        data_a = v;
        @(posedge clk);
        #1;
        check(tag, pulse_a, exp);
    endtask

    task automatic step_b(input logic [7:0] v, input logic exp, input string tag);
        data_b = v;
        @(posedge clk);
        #1;
        check(tag, pulse_b, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_a  = 1'b1;
        rst_b  = 1'b1;
        data_a = 8'h00;
        data_b = 8'h00;
        #2;
        check("reset_a", pulse_a, 1'b0);
        check("reset_b", pulse_b, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held_a", pulse_a, 1'b0);
        rst_a = 1'b0;

        // Constant zero after reset: first edge compares 0 against reset value 0
        step_a(8'h00, 1'b0, "zero_e1");
        step_a(8'h00, 1'b0, "zero_e2");
        step_a(8'h00, 1'b0, "zero_e3");

        // 0x00 -> 0x05 -> 0x02 -> 0x02 held
        step_a(8'h05, 1'b1, "seq_05");
        step_a(8'h02, 1'b1, "seq_02");
        step_a(8'h02, 1'b0, "seq_02_hold1");
        step_a(8'h02, 1'b0, "seq_02_hold2");

        // Consecutive changes keep pulse continuously high
        step_a(8'h15, 1'b1, "tog_15");
        step_a(8'h30, 1'b1, "tog_30");
        step_a(8'h10, 1'b1, "tog_10");
        step_a(8'h40, 1'b1, "tog_40");
        step_a(8'h40, 1'b0, "tog_hold1");
        step_a(8'h40, 1'b0, "tog_hold2");

        // Glitch away and back between edges is invisible
        data_a = 8'h55;
        #2;
        step_a(8'h40, 1'b0, "glitch");

        // Decrease and a single-bit toggle both count as changes
        step_a(8'h3F, 1'b1, "decrease");
        step_a(8'h3E, 1'b1, "bit0_toggle");
        step_a(8'h3E, 1'b0, "bit0_hold");

        // PULSE_CYCLES=4 instance: release with zero data
        rst_b = 1'b0;
        step_b(8'h00, 1'b0, "b_rel_zero");
        step_b(8'h10, 1'b1, "b_10_c1");
        step_b(8'h10, 1'b1, "b_10_c2");
        step_b(8'h10, 1'b1, "b_10_c3");
        step_b(8'h10, 1'b1, "b_10_c4");
        step_b(8'h10, 1'b0, "b_10_end");
        step_b(8'h20, 1'b1, "b_20_c1");
        step_b(8'h20, 1'b1, "b_20_c2");
        step_b(8'h21, 1'b1, "b_21_reload");
        step_b(8'h21, 1'b1, "b_21_c2");
        step_b(8'h21, 1'b1, "b_21_c3");
        step_b(8'h21, 1'b1, "b_21_c4");
        step_b(8'h21, 1'b0, "b_21_end");

        // Reset mid-pulse clears pulse without a clock edge
        step_b(8'h33, 1'b1, "b_33_c1");
        step_b(8'h33, 1'b1, "b_33_c2");
        rst_b = 1'b1;
        #1;
        check("b_async_reset", pulse_b, 1'b0);
        @(posedge clk);
        #1;
        check("b_reset_held", pulse_b, 1'b0);
        data_b = 8'h00;
        rst_b  = 1'b0;
        step_b(8'h00, 1'b0, "b_post_rst1");
        step_b(8'h00, 1'b0, "b_post_rst2");
        step_b(8'h00, 1'b0, "b_post_rst3");

        // Release with non-zero data: pulse at first edge, none while held
        rst_a = 1'b1;
        #1;
        check("a_reset_again", pulse_a, 1'b0);
        data_a = 8'hA5;
        rst_a  = 1'b0;
        step_a(8'hA5, 1'b1, "rel_a5");
        step_a(8'hA5, 1'b0, "a5_hold1");
        step_a(8'hA5, 1'b0, "a5_hold2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pulse_on_change.md
PULSE_ON_CHANGE -- requirements
Module: pulse_on_change

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data bus width in bits (legal range 1..64).
REQ-002 The block SHALL have parameter PULSE_CYCLES, default 1, giving the pulse length in clock cycles (legal range 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, the reset; it is asynchronous and active-high (1 = reset asserted), and the name is kept for codebase consistency.
REQ-005 The block SHALL have port data_in, input, WIDTH bits, the monitored data word, synchronous to clk.
REQ-006 The block SHALL have port pulse, output, 1 bit, registered, high while a change-indication pulse is active.

Function
REQ-007 The block SHALL hold a WIDTH-bit register prev_data that captures data_in on every rising clk edge while reset is deasserted.
REQ-008 A change event SHALL be detected at a rising edge when data_in != prev_data, compared over all WIDTH bits.
- Any bit difference counts, whether the value increases, decreases or toggles.
REQ-009 On a change event the block SHALL load an internal down-counter with PULSE_CYCLES.
- Counter width is ceil(log2(PULSE_CYCLES+1)), minimum 1 bit.
REQ-010 pulse SHALL be driven from a flop and be 1 exactly when the counter is non-zero after the edge.
- Latency: pulse rises on the same rising edge at which the change is sampled, i.e. 1 edge after data_in changes between edges.
REQ-011 With no change event at an edge and counter > 0, the counter SHALL decrement by 1; at 0 it SHALL hold 0.
REQ-012 The pulse SHALL be retriggerable: a change event while pulse is high SHALL reload the counter to PULSE_CYCLES.
- No additional edge or gap is inserted.
- Changes on consecutive edges keep pulse continuously high.
REQ-013 With PULSE_CYCLES=1, an isolated change SHALL produce pulse high for exactly one clk period.
REQ-014 A data_in value that changes and returns to the original value between two rising edges SHALL NOT be detected.
- Only sampled values are compared.
REQ-015 data_in remaining constant (including re-driving the same value) SHALL NOT generate a pulse.
REQ-016 The block SHALL contain no combinational path from data_in to pulse.

Reset
REQ-017 While rst_n=1, prev_data SHALL be forced to all zeros, the counter to 0 and pulse to 0, asynchronously and without waiting for clk.
REQ-018 Reset asserted mid-pulse SHALL immediately drive pulse to 0 and discard the pending count.
REQ-019 At the first rising edge after reset deassertion, data_in SHALL be compared against the reset value 0.
- Non-zero data_in at that edge generates a pulse.
- data_in=0 at that edge does not generate a pulse.
REQ-020 Reset deassertion SHALL take effect at the next rising clk edge; the same edge performs a normal compare/capture.

Verification
REQ-021 WIDTH=8, PULSE_CYCLES=1: reset, then data_in held at 0x00 for 3 edges -> pulse stays 0 throughout.
REQ-022 WIDTH=8, PULSE_CYCLES=1, per-edge sequence:
- Stimulus: 0x00, then 0x05, then 0x02, then 0x02 held.
- Response: pulse=1 for one cycle after 0x05 is sampled, 1 for one cycle after 0x02 is sampled, then 0.
REQ-023 WIDTH=8, PULSE_CYCLES=1, rapid toggling 0x15->0x30->0x10->0x40 on consecutive edges, then held -> pulse high continuously for 4 cycles, then 0.
REQ-024 WIDTH=8, PULSE_CYCLES=4: single change 0x10->0x20 -> pulse high exactly 4 cycles.
- Second change 0x20->0x21 while pulse high -> count restarts, pulse high 4 cycles from the second change.
REQ-025 WIDTH=8, PULSE_CYCLES=4: assert rst_n=1 between clock edges while pulse is high -> pulse=0 immediately.
- After release with data_in=0x00 -> no pulse.
REQ-026 Reset released with data_in=0xA5 -> pulse=1 after the first edge; data_in held at 0xA5 -> no further pulse.
